note_player: RTL and testbench

- Sits directly downstream of song_reader_new.
- Accepts one note at a time over the new_note/note_done handshake, holds it for its duration counted in beat pulses, and drives the phase-increment (step_size) that the sine/sample generator consumes.
- Issues note_done when the duration expires so song_reader_new advances.

---
 rtl/note_player_pkg.sv | 16 +
 rtl/frequency_rom.sv | 51 +++++
 rtl/note_player.sv | 83 ++++++++
 tb/tb_note_player.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// Shared definitions for the song player: field widths, note-player state
// encoding and metadata bit positions used by song_reader_new and note_player.
package note_player_pkg;

    localparam int NOTE_WIDTH    = 6;
    localparam int META_WIDTH    = 3;
    localparam int STEP_WIDTH    = 20;
    localparam int META_REST_BIT = 0;

    typedef enum logic [1:0] {
        NP_IDLE    = 2'd0,
        NP_PLAYING = 2'd1,
        NP_FINISH  = 2'd2
    } np_state_e;

endpackage

// File: rtl/frequency_rom.sv
// Equal-tempered phase-increment table (fs = 48 kHz, 2^20 phase, note 49 = A4).
// Registered output; mute_i clears the output on the next edge.
module frequency_rom
    import note_player_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mute_i,
    input  logic [5:0]            addr_i,
    output logic [STEP_WIDTH-1:0] data_o
);

    logic [STEP_WIDTH-1:0] lut;
    logic [STEP_WIDTH-1:0] data_q;

    always_comb begin
        // NOTE: every always_comb path assigns its outputs (via the default) so no latch is inferred.
        lut = '0;
        case (addr_i)
            6'd1:  lut = 20'd601;   6'd2:  lut = 20'd636;   6'd3:  lut = 20'd674;   6'd4:  lut = 20'd714;
            6'd5:  lut = 20'd757;   6'd6:  lut = 20'd802;   6'd7:  lut = 20'd850;   6'd8:  lut = 20'd900;
            6'd9:  lut = 20'd954;   6'd10: lut = 20'd1010;  6'd11: lut = 20'd1070;  6'd12: lut = 20'd1134;
            6'd13: lut = 20'd1201;  6'd14: lut = 20'd1273;  6'd15: lut = 20'd1349;  6'd16: lut = 20'd1429;
            6'd17: lut = 20'd1514;  6'd18: lut = 20'd1604;  6'd19: lut = 20'd1699;  6'd20: lut = 20'd1800;
            6'd21: lut = 20'd1907;  6'd22: lut = 20'd2021;  6'd23: lut = 20'd2141;  6'd24: lut = 20'd2268;
            6'd25: lut = 20'd2403;  6'd26: lut = 20'd2546;  6'd27: lut = 20'd2697;  6'd28: lut = 20'd2858;
            6'd29: lut = 20'd3028;  6'd30: lut = 20'd3208;  6'd31: lut = 20'd3398;  6'd32: lut = 20'd3600;
            6'd33: lut = 20'd3814;  6'd34: lut = 20'd4041;  6'd35: lut = 20'd4282;  6'd36: lut = 20'd4536;
            6'd37: lut = 20'd4806;  6'd38: lut = 20'd5092;  6'd39: lut = 20'd5394;  6'd40: lut = 20'd5715;
            6'd41: lut = 20'd6055;  6'd42: lut = 20'd6415;  6'd43: lut = 20'd6797;  6'd44: lut = 20'd7201;
            6'd45: lut = 20'd7629;  6'd46: lut = 20'd8083;  6'd47: lut = 20'd8563;  6'd48: lut = 20'd9072;
            6'd49: lut = 20'd9612;  6'd50: lut = 20'd10184; 6'd51: lut = 20'd10789; 6'd52: lut = 20'd11431;
            6'd53: lut = 20'd12110; 6'd54: lut = 20'd12830; 6'd55: lut = 20'd13593; 6'd56: lut = 20'd14402;
            6'd57: lut = 20'd15258; 6'd58: lut = 20'd16165; 6'd59: lut = 20'd17127; 6'd60: lut = 20'd18145;
            6'd61: lut = 20'd19224; 6'd62: lut = 20'd20367; 6'd63: lut = 20'd21578;
            default: lut = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset || mute_i) begin
            data_q <= '0;
        end else begin
            data_q <= lut;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/note_player.sv
// Holds one note for its beat-counted duration, drives the phase increment for
// the sample generator and pulses note_done so the song reader advances.
module note_player
    import note_player_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  beat,
    input  logic                  new_note,
    input  logic [NOTE_WIDTH-1:0] note,
    input  logic [NOTE_WIDTH-1:0] duration,
    input  logic [META_WIDTH-1:0] metadata,
    output logic                  note_done,
    output logic                  note_active,
    output logic [STEP_WIDTH-1:0] step_size,
    output logic [META_WIDTH-1:0] meta_out
);

    np_state_e             state_q, state_d;
    logic [NOTE_WIDTH-1:0] beats_left_q, beats_left_d;
    logic [NOTE_WIDTH-1:0] note_q, note_d;
    logic [META_WIDTH-1:0] meta_q, meta_d;
    logic                  mute;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= NP_IDLE;
            beats_left_q <= '0;
            note_q       <= '0;
            meta_q       <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            note_q       <= note_d;
            meta_q       <= meta_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        note_d       = note_q;
        meta_d       = meta_q;
        // A fresh note overrides everything, including a final beat of the old one.
        if (new_note) begin
            note_d       = note;
            beats_left_d = duration;
            meta_d       = metadata;
            state_d      = (duration == '0) ? NP_FINISH : NP_PLAYING;
        end else begin
            case (state_q)
                NP_PLAYING: begin
                    if (beat && play) begin
                        if (beats_left_q <= NOTE_WIDTH'(1)) begin
                            beats_left_d = '0;
                            state_d      = NP_FINISH;
                        end else begin
                            beats_left_d = beats_left_q - NOTE_WIDTH'(1);
                        end
                    end
                end
                NP_FINISH: state_d = NP_IDLE;
                default:   state_d = state_q;
            endcase
        end
    end

    assign mute = (state_q != NP_PLAYING) || !play || (note_q == '0) || meta_q[META_REST_BIT];

    frequency_rom u_rom (
        .clk    (clk),
        .reset  (reset),
        .mute_i (mute),
        .addr_i (note_q),
        .data_o (step_size)
    );

    assign note_done   = (state_q == NP_FINISH);
    assign note_active = (state_q == NP_PLAYING);
    assign meta_out    = meta_q;

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: per-cycle expected outputs queued as
// stimulus is driven and compared one time unit after each rising edge.
module tb_note_player;
    import note_player_pkg::*;

    typedef struct packed {
        logic       rst;
        logic       play;
        logic       beat;
        logic       nn;
        logic [5:0] note;
        logic [5:0] dur;
        logic [2:0] meta;
    } in_t;

    typedef struct packed {
        logic        done;
        logic        act;
        logic [19:0] step;
        logic [2:0]  meta;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int ROM_REF [64] = '{
        0,     601,   636,   674,   714,   757,   802,   850,
        900,   954,   1010,  1070,  1134,  1201,  1273,  1349,
        1429,  1514,  1604,  1699,  1800,  1907,  2021,  2141,
        2268,  2403,  2546,  2697,  2858,  3028,  3208,  3398,
        3600,  3814,  4041,  4282,  4536,  4806,  5092,  5394,
        5715,  6055,  6415,  6797,  7201,  7629,  8083,  8563,
        9072,  9612,  10184, 10789, 11431, 12110, 12830, 13593,
        14402, 15258, 16165, 17127, 18145, 19224, 20367, 21578
    };

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  play;
    logic                  beat;
    logic                  new_note;
    logic [NOTE_WIDTH-1:0] note;
    logic [NOTE_WIDTH-1:0] duration;
    logic [META_WIDTH-1:0] metadata;
    logic                  note_done;
    logic                  note_active;
    logic [STEP_WIDTH-1:0] step_size;
    logic [META_WIDTH-1:0] meta_out;

    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    out_t exp_q[$];
    vec_t tbl[$];

    note_player dut (
        .clk         (clk),
        .reset       (reset),
        .play        (play),
        .beat        (beat),
        .new_note    (new_note),
        .note        (note),
        .duration    (duration),
        .metadata    (metadata),
        .note_done   (note_done),
        .note_active (note_active),
        .step_size   (step_size),
        .meta_out    (meta_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected step is given as the note index whose table entry should be heard.
    function automatic vec_t mk(input int rst, play_v, beat_v, nn, note_v, dur, meta,
                                input int done, act, snote, emeta);
        vec_t v;
        int   s;
        s          = ROM_REF[snote];
        v.i.rst    = rst[0];
        v.i.play   = play_v[0];
        v.i.beat   = beat_v[0];
        v.i.nn     = nn[0];
        v.i.note   = note_v[5:0];
        v.i.dur    = dur[5:0];
        v.i.meta   = meta[2:0];
        v.o.done   = done[0];
        v.o.act    = act[0];
        v.o.step   = s[19:0];
        v.o.meta   = emeta[2:0];
        return v;
    endfunction

    task automatic add(input int rst, play_v, beat_v, nn, note_v, dur, meta,
                       input int done, act, snote, emeta);
        tbl.push_back(mk(rst, play_v, beat_v, nn, note_v, dur, meta, done, act, snote, emeta));
    endtask

    task automatic apply(input vec_t v, input string tag);
        out_t  e;
        string n;
        reset    = v.i.rst;
        play     = v.i.play;
        beat     = v.i.beat;
        new_note = v.i.nn;
        note     = v.i.note;
        duration = v.i.dur;
        metadata = v.i.meta;
        exp_q.push_back(v.o);
        @(posedge clk);
        #1;
        cyc_n++;
        e = exp_q.pop_front();
        n = $sformatf("%s c%0d", tag, cyc_n);
        check({n, " note_done"},   int'(note_done),   int'(e.done));
        check({n, " note_active"}, int'(note_active), int'(e.act));
        check({n, " step_size"},   int'(step_size),   int'(e.step));
        check({n, " meta_out"},    int'(meta_out),    int'(e.meta));
    endtask

    task automatic cyc(input string tag, input int rst, play_v, beat_v, nn, note_v, dur, meta,
                       input int done, act, snote, emeta);
        apply(mk(rst, play_v, beat_v, nn, note_v, dur, meta, done, act, snote, emeta), tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Columns: rst play beat new_note note dur meta | done active step_note meta_out
        // Basic note 37, three beats
        add(1,1,0,1,37,3,0, 0,1,0,0);
        add(1,1,0,0,0,0,0,  0,1,37,0);
        add(1,1,1,0,0,0,0,  0,1,37,0);
        add(1,1,0,0,0,0,0,  0,1,37,0);
        add(1,1,1,0,0,0,0,  0,1,37,0);
        add(1,1,1,0,0,0,0,  1,0,37,0);
        add(1,1,0,0,0,0,0,  0,0,0,0);
        add(1,1,0,0,0,0,0,  0,0,0,0);
        // Pause: beats with play=0 are ignored and the output is silenced
        add(1,1,0,1,10,2,6, 0,1,0,6);
        add(1,1,0,0,0,0,0,  0,1,10,6);
        add(1,1,1,0,0,0,0,  0,1,10,6);
        add(1,0,0,0,0,0,0,  0,1,0,6);
        add(1,0,1,0,0,0,0,  0,1,0,6);
        add(1,0,1,0,0,0,0,  0,1,0,6);
        add(1,0,1,0,0,0,0,  0,1,0,6);
        add(1,1,0,0,0,0,0,  0,1,10,6);
        add(1,1,1,0,0,0,0,  1,0,10,6);
        add(1,1,0,0,0,0,0,  0,0,0,6);
        // Rest note index 0
        add(1,1,0,1,0,2,0,  0,1,0,0);
        add(1,1,1,0,0,0,0,  0,1,0,0);
        add(1,1,1,0,0,0,0,  1,0,0,0);
        add(1,1,0,0,0,0,0,  0,0,0,0);
        // Forced rest via metadata bit 0
        add(1,1,0,1,20,2,1, 0,1,0,1);
        add(1,1,0,0,0,0,0,  0,1,0,1);
        add(1,1,1,0,0,0,0,  0,1,0,1);
        add(1,1,1,0,0,0,0,  1,0,0,1);
        add(1,1,0,0,0,0,0,  0,0,0,1);

        reset = 1'b0; play = 1'b1; beat = 1'b0; new_note = 1'b0;
        note = '0; duration = '0; metadata = '0;

        cyc("reset", 0,1,0,0,0,0,0, 0,0,0,0);
        cyc("reset", 0,1,0,0,0,0,0, 0,0,0,0);

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k], "tbl");

        cyc("dur0", 1,1,0,1,5,0,0, 1,0,0,0);
        cyc("dur0", 1,1,0,0,0,0,0, 0,0,0,0);

        cyc("restart", 1,1,0,1,5,4,0, 0,1,0,0);
        cyc("restart", 1,1,1,0,0,0,0, 0,1,5,0);
        cyc("restart", 1,1,1,0,0,0,0, 0,1,5,0);
        cyc("restart", 1,1,0,1,9,1,0, 0,1,5,0);
        cyc("restart", 1,1,0,0,0,0,0, 0,1,9,0);
        cyc("restart", 1,1,1,0,0,0,0, 1,0,9,0);
        cyc("restart", 1,1,0,0,0,0,0, 0,0,0,0);

        cyc("collide", 1,1,0,1,3,1,0,  0,1,0,0);
        cyc("collide", 1,1,0,0,0,0,0,  0,1,3,0);
        cyc("collide", 1,1,1,1,12,2,0, 0,1,3,0);
        cyc("collide", 1,1,0,0,0,0,0,  0,1,12,0);
        cyc("collide", 1,1,1,0,0,0,0,  0,1,12,0);
        cyc("collide", 1,1,1,0,0,0,0,  1,0,12,0);
        cyc("collide", 1,1,0,0,0,0,0,  0,0,0,0);

        cyc("midreset", 1,1,0,1,37,4,4, 0,1,0,4);
        cyc("midreset", 1,1,1,0,0,0,0,  0,1,37,4);
        cyc("midreset", 1,1,1,0,0,0,0,  0,1,37,4);
        cyc("midreset", 0,1,0,0,0,0,0,  0,0,0,0);
        cyc("midreset", 0,1,1,0,0,0,0,  0,0,0,0);
        cyc("midreset", 1,1,1,0,0,0,0,  0,0,0,0);
        cyc("midreset", 1,1,1,0,0,0,0,  0,0,0,0);
        cyc("midreset", 1,1,0,0,0,0,0,  0,0,0,0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
